// File: rtl/irrigation_timer_ctrl_if.sv
// Control and display bundle between the irrigation timer and its environment:
// user controls, preset digits, digit outputs, valve and status pulses.
interface irrigation_timer_ctrl_if;
  logic       tick;
  logic       start;
  logic       abort;
  logic       pause;
  logic [3:0] preset_min;
  logic [3:0] preset_st;
  logic [3:0] preset_su;
  logic [3:0] min_digit;
  logic [3:0] st_digit;
  logic [3:0] su_digit;
  logic       valve;
  logic       done;
  logic       err;
  logic [1:0] state;

  modport master (
    output tick, start, abort, pause, preset_min, preset_st, preset_su,
    input  min_digit, st_digit, su_digit, valve, done, err, state
  );

  modport slave (
    input  tick, start, abort, pause, preset_min, preset_st, preset_su,
    output min_digit, st_digit, su_digit, valve, done, err, state
  );
endinterface

// File: rtl/irrigation_timer_ctrl.sv
// Irrigation countdown timer: loads an M:SS BCD preset, counts it down on each
// 1 Hz tick through a mod-10/mod-6/mod-10 borrow chain and opens the valve while running.
module irrigation_timer_ctrl (
  input  logic                          clk,
  input  logic                          clear_n,
  irrigation_timer_ctrl_if.slave        bus
);

  localparam int unsigned DigitW = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_HOLD   = 2'b10,
    S_FINISH = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [DigitW-1:0]   min_q, min_d;
  logic [DigitW-1:0]   st_q, st_d;
  logic [DigitW-1:0]   su_q, su_d;
  logic                valve_q, valve_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                preset_ok;
  logic                preset_zero;
  logic                last_second;

  assign preset_ok   = (bus.preset_min <= DigitW'(9)) && (bus.preset_st <= DigitW'(5)) &&
                       (bus.preset_su <= DigitW'(9));
  assign preset_zero = (bus.preset_min == '0) && (bus.preset_st == '0) && (bus.preset_su == '0);
  assign last_second = (min_q == '0) && (st_q == '0) && (su_q == DigitW'(1));

  // Next-state, digit update and registered-output decode
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    st_d    = st_q;
    su_d    = su_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!preset_ok) begin
            err_d = 1'b1;
          end else begin
            min_d   = bus.preset_min;
            st_d    = bus.preset_st;
            su_d    = bus.preset_su;
            state_d = preset_zero ? S_FINISH : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (bus.pause) begin
          state_d = S_HOLD;
        end else if (bus.tick) begin
          if (su_q != '0) begin
            su_d = su_q - DigitW'(1);
          end else if (st_q != '0) begin
            su_d = DigitW'(9);
            st_d = st_q - DigitW'(1);
          end else if (min_q != '0) begin
            su_d  = DigitW'(9);
            st_d  = DigitW'(5);
            min_d = min_q - DigitW'(1);
          end
          if (last_second) state_d = S_FINISH;
        end
      end
      S_HOLD: begin
        if (!bus.pause) state_d = S_RUN;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a start rejection
    if (bus.abort) begin
      state_d = S_IDLE;
      min_d   = '0;
      st_d    = '0;
      su_d    = '0;
      err_d   = 1'b0;
    end

    valve_d = (state_d == S_RUN);
    done_d  = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      min_q   <= '0;
      st_q    <= '0;
      su_q    <= '0;
      valve_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      st_q    <= st_d;
      su_q    <= su_d;
      valve_q <= valve_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.min_digit = min_q;
  assign bus.st_digit  = st_q;
  assign bus.su_digit  = su_q;
  assign bus.valve     = valve_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// Directed bench for irrigation_timer_ctrl: countdown, borrow chain, invalid
// presets, pause/hold, abort, asynchronous clear and zero preset.
module tb_irrigation_timer_ctrl;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  irrigation_timer_ctrl_if bus();

  irrigation_timer_ctrl dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd(input int m, input int s);
    return {4'(m), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [11:0] cur();
    return {bus.min_digit, bus.st_digit, bus.su_digit};
  endfunction

  task automatic chk_all(input string tag, input logic [11:0] dig, input logic [1:0] st,
                         input logic v, input logic d, input logic e);
    chk({tag, "_digits"}, cur(), dig);
    chk({tag, "_state"}, 12'(bus.state), 12'(st));
    chk({tag, "_valve"}, 12'(bus.valve), 12'(v));
    chk({tag, "_done"}, 12'(bus.done), 12'(d));
    chk({tag, "_err"}, 12'(bus.err), 12'(e));
  endtask

  // Advance one clock edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_preset(input int m, input int sec_t, input int sec_u);
    bus.preset_min = 4'(m);
    bus.preset_st  = 4'(sec_t);
    bus.preset_su  = 4'(sec_u);
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic tick_once();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
    set_preset(0, 0, 0);
    #3;
    chk_all("reset", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);
    #14 clear_n = 1'b1;
    step();

    // 0:12 countdown
    set_preset(0, 1, 2);
    start_pulse();
    chk_all("t1_load", bcd(0, 12), 2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick_once();
      chk("t1_digits", cur(), bcd(0, 12 - i));
      if (i < 12) chk("t1_valve", 12'(bus.valve), 12'd1);
    end
    chk_all("t1_finish", bcd(0, 0), 2'b11, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t1_idle", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);

    // 1:00 with a tick coincident with the accepting start edge
    set_preset(1, 0, 0);
    bus.tick = 1'b1;
    start_pulse();
    bus.tick = 1'b0;
    chk_all("t2_load", bcd(1, 0), 2'b01, 1'b1, 1'b0, 1'b0);
    tick_once();
    chk_all("t2_borrow", bcd(0, 59), 2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 58; i++) tick_once();
    chk_all("t2_last1", bcd(0, 1), 2'b01, 1'b1, 1'b0, 1'b0);
    step();
    chk("t2_idle_gap", cur(), bcd(0, 1));
    tick_once();
    chk_all("t2_finish", bcd(0, 0), 2'b11, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t2_idle", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);

    // Invalid presets: seconds-tens 6, then minutes 10
    set_preset(0, 6, 0);
    start_pulse();
    chk_all("t3_err_st", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    chk_all("t3_err_gone", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);
    set_preset(10, 0, 5);
    start_pulse();
    chk_all("t3_err_min", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b1);
    step();
    chk("t3_err_min_gone", 12'(bus.err), 12'd0);

    // 0:05 with pause; tick arriving with pause is discarded
    set_preset(0, 0, 5);
    start_pulse();
    tick_once();
    tick_once();
    chk_all("t4_run", bcd(0, 3), 2'b01, 1'b1, 1'b0, 1'b0);
    bus.pause = 1'b1;
    tick_once();
    chk_all("t4_hold", bcd(0, 3), 2'b10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick_once();
      step();
    end
    chk_all("t4_hold_ticks", bcd(0, 3), 2'b10, 1'b0, 1'b0, 1'b0);
    bus.pause = 1'b0;
    step();
    chk_all("t4_resume", bcd(0, 3), 2'b01, 1'b1, 1'b0, 1'b0);
    tick_once();
    chk("t4_d2", cur(), bcd(0, 2));
    tick_once();
    chk("t4_d1", cur(), bcd(0, 1));
    tick_once();
    chk_all("t4_finish", bcd(0, 0), 2'b11, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t4_idle", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);

    // 0:30, abort coincident with a tick
    set_preset(0, 3, 0);
    start_pulse();
    for (int i = 0; i < 10; i++) tick_once();
    chk_all("t5_mid", bcd(0, 20), 2'b01, 1'b1, 1'b0, 1'b0);
    bus.abort = 1'b1;
    bus.tick  = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.tick  = 1'b0;
    chk_all("t5_abort", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    chk("t5_no_done", 12'(bus.done), 12'd0);

    // 0:30 again, asynchronous clear mid-run
    start_pulse();
    for (int i = 0; i < 5; i++) tick_once();
    chk_all("t5b_mid", bcd(0, 25), 2'b01, 1'b1, 1'b0, 1'b0);
    #2 clear_n = 1'b0;
    #1;
    chk_all("t5b_clear", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);
    #3 clear_n = 1'b1;
    step();
    chk_all("t5b_after", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);

    // Zero preset goes straight to FINISH
    set_preset(0, 0, 0);
    start_pulse();
    chk_all("t6_finish", bcd(0, 0), 2'b11, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("t6_idle", bcd(0, 0), 2'b00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
